vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA raster timing generator for displays driven by the FPGA's pixel pipeline. It produces horizontal and vertical counters, scaled memory coordinates, sync and blanking strobes, and frame/line markers, all from a single `vga_clock`. The pixel rate comes from a clock-enable rather than a derived clock. Porch and sync widths, the clock divider, the coordinate scale, sync polarity and the strobe pipeline depth are all parameters, so one block serves 640x480 and non-standard/simulation-sized modes.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, pixels
- `H_SYNC`, 96: horizontal sync width, pixels
- `H_BP`, 48: horizontal back porch, pixels
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch, lines
- `V_SYNC`, 2: vertical sync width, lines
- `V_BP`, 33: vertical back porch, lines
- `CLK_DIV`, 2: `vga_clock` cycles per pixel, range 1..16
- `SCALE_SHIFT`, 0: coordinate right-shift (0=640x480, 1=320x240, 2=160x120)
- `HS_POL`, 0: active level of `VGA_HS`
- `VS_POL`, 0: active level of `VGA_VS`
- `PIPE_DELAY`, 1: pixel delay of sync/visible relative to counters, range 0..4
- `CW`, 11: counter width; H_TOTAL and V_TOTAL must be ≤ 2^CW
- `vga_clock`  in  1  system/video clock
- `reset`  in  1  asynchronous, active-high reset
- `enable`  in  1  1 = raster runs; 0 = freeze all state
- `pixel_en`  out  1  one-cycle pixel strobe
- `hcount`  out  CW  raw horizontal position, 0..H_TOTAL-1
- `vcount`  out  CW  raw vertical position, 0..V_TOTAL-1
- `xCoord`  out  CW  hcount >> SCALE_SHIFT
- `yCoord`  out  CW  vcount >> SCALE_SHIFT
- `VGA_HS`, `VGA_VS`  out  1 each  sync outputs, polarity per parameter
- `visible`  out  1  active-video flag, delayed
- `VGA_SYNC_N`  out  1  constant 1
- `line_start`, `frame_start`  out  1 each  one-cycle markers
- `frame_count`  out  16  completed-frame counter

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is computed the same way from the vertical parameters.
- Divider `div_cnt` counts 0..CLK_DIV-1 on each `vga_clock` when `enable`=1, then wraps.
  - `pixel_en` = enable && div_cnt==CLK_DIV-1 (combinational).
  - With CLK_DIV=1, `pixel_en` = enable.
- On each `pixel_en`:
  - `hcount` increments; at H_TOTAL-1 it wraps to 0 and `vcount` increments.
  - `vcount` wraps from V_TOTAL-1 to 0 at the line end.
- `xCoord`/`yCoord` are combinational shifts. They are not clamped during blanking.
- Raw strobes are computed from the current counters:
  - hs_raw = hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], exactly H_SYNC pixels.
  - vs_raw is the vertical equivalent, exactly V_SYNC lines.
  - vis_raw = hcount<H_ACTIVE && vcount<V_ACTIVE.
- Raw strobes pass through PIPE_DELAY register stages, each advanced only on `pixel_en`. PIPE_DELAY=0 means combinational pass-through.
- `VGA_HS` = delayed hs_raw ? HS_POL : ~HS_POL. `VGA_VS` is formed the same way from VS_POL.
- `line_start` = pixel_en && hcount==0. `frame_start` = line_start && vcount==0. Both are undelayed, combinational, and one `vga_clock` wide.
- `frame_count` increments on the `pixel_en` where hcount==H_TOTAL-1 and vcount==V_TOTAL-1. It wraps modulo 2^16.
- `enable`=0 holds div_cnt, counters, pipeline and frame_count. All strobes are 0 and sync/visible hold their last value.

## Timing
- Reset values:
  - div_cnt, hcount, vcount, frame_count = 0
  - xCoord, yCoord = 0
  - pipeline stages = 0, so `visible`=0 and sync outputs at their inactive level
  - `VGA_SYNC_N`=1
  - `pixel_en`, `line_start`, `frame_start` follow their combinational definitions from the reset counters: 0 during reset when CLK_DIV>1
- After `reset` falls with `enable`=1:
  - First `pixel_en` on the CLK_DIV-th rising edge.
  - That cycle also asserts `line_start` and `frame_start`, for pixel (0,0).
- Sync/visible for pixel (h,v) appear PIPE_DELAY pixel periods (PIPE_DELAY·CLK_DIV cycles) after hcount=h, vcount=v.
- Frame period is H_TOTAL·V_TOTAL·CLK_DIV `vga_clock` cycles while `enable`=1.
- Reset mid-frame forces all reset values on the next evaluation, with no glitch handling required. Reset dominates `enable`.
- Simultaneous wraps: at (H_TOTAL-1,V_TOTAL-1), hcount, vcount and frame_count all update on the same edge.

## Test plan
- Defaults, reset released:
  - `pixel_en` period is 2 cycles.
  - `frame_start` pulses are 840000 cycles apart.
  - `frame_count` reads 1 after the first pulse-to-pulse interval, starting 0.
- Defaults, HS/VS widths:
  - `VGA_HS` is low for exactly 96 pixels per line, first low pixel when the delayed hcount=656.
  - `VGA_VS` is low for exactly 2 lines (delayed vcount 490..491).
  - `visible` is high for exactly 640·480 pixels per frame.
- SCALE_SHIFT=2:
  - hcount=639, vcount=479 gives xCoord=159, yCoord=119.
  - hcount=3 gives xCoord=0.
- Small mode (H: 8/2/3/3, V: 4/1/2/1, CLK_DIV=1, PIPE_DELAY=0, HS_POL=1):
  - Frame is 128 cycles.
  - `VGA_HS` is high at hcount 10..12.
  - `visible` is high 32 cycles per frame.
- `enable` low for 50 cycles mid-line:
  - Counters, frame_count and pipeline are frozen.
  - No strobes during the pause.
  - Raster resumes at the same position.
- Assert `reset` at hcount=300, vcount=200:
  - All outputs return to their reset values.
  - After release, the first `frame_start` occurs after CLK_DIV cycles.

Source files
------------

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA raster timing generator. A clock-enable divider produces the
// pixel strobe; horizontal/vertical counters walk the raster; sync and
// active-video strobes are derived from the counters and delayed through a
// short pipeline so they line up with downstream pixel data.
//
// Ports
//   vga_clock    in   system/video clock
//   reset        in   asynchronous, active-high reset
//   enable       in   1 = raster runs, 0 = all state frozen
//   pixel_en     out  one-cycle pixel strobe (enable && divider at last count)
//   hcount       out  raw horizontal position, 0..H_TOTAL-1
//   vcount       out  raw vertical position, 0..V_TOTAL-1
//   xCoord       out  hcount >> SCALE_SHIFT
//   yCoord       out  vcount >> SCALE_SHIFT
//   VGA_HS       out  horizontal sync, active level HS_POL, delayed
//   VGA_VS       out  vertical sync, active level VS_POL, delayed
//   visible      out  active-video flag, delayed
//   VGA_SYNC_N   out  constant 1
//   line_start   out  pixel_en at hcount == 0 (undelayed)
//   frame_start  out  line_start at vcount == 0 (undelayed)
//   frame_count  out  completed-frame counter, wraps modulo 2^16
// -----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int   H_ACTIVE    = 640,
    parameter int   H_FP        = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   V_ACTIVE    = 480,
    parameter int   V_FP        = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 33,
    parameter int   CLK_DIV     = 2,
    parameter int   SCALE_SHIFT = 0,
    parameter logic HS_POL      = 1'b0,
    parameter logic VS_POL      = 1'b0,
    parameter int   PIPE_DELAY  = 1,
    parameter int   CW          = 11
) (
    input  logic          vga_clock,
    input  logic          reset,
    input  logic          enable,
    output logic          pixel_en,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic [CW-1:0] xCoord,
    output logic [CW-1:0] yCoord,
    output logic          VGA_HS,
    output logic          VGA_VS,
    output logic          visible,
    output logic          VGA_SYNC_N,
    output logic          line_start,
    output logic          frame_start,
    output logic [15:0]   frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);

    logic [DW-1:0] r_div_cnt;
    logic [CW-1:0] r_hcount;
    logic [CW-1:0] r_vcount;
    logic [15:0]   r_frame_count;

    logic          w_pixel_en;
    logic          w_h_last;
    logic          w_v_last;
    logic [2:0]    w_raw;      // {hs, vs, vis} from the current counters
    logic [2:0]    w_delayed;  // same strobes after PIPE_DELAY pixel stages

    assign w_pixel_en = enable && (r_div_cnt == DIV_LAST);
    assign w_h_last   = (r_hcount == H_LAST);
    assign w_v_last   = (r_vcount == V_LAST);

    // Pixel divider: only advances while enabled, so a pause holds the phase.
    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
        end else if (enable) begin
            if (r_div_cnt == DIV_LAST) r_div_cnt <= '0;
            else                       r_div_cnt <= r_div_cnt + DW'(1);
        end
    end

    // Raster counters; hcount, vcount and frame_count all step on the same
    // edge at the last pixel of the frame.
    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_frame_count <= '0;
        end else if (w_pixel_en) begin
            if (w_h_last) begin
                r_hcount <= '0;
                if (w_v_last) begin
                    r_vcount      <= '0;
                    r_frame_count <= r_frame_count + 16'd1;
                end else begin
                    r_vcount <= r_vcount + CW'(1);
                end
            end else begin
                r_hcount <= r_hcount + CW'(1);
            end
        end
    end

    assign w_raw[2] = (r_hcount >= HS_FIRST) && (r_hcount <= HS_LAST);
    assign w_raw[1] = (r_vcount >= VS_FIRST) && (r_vcount <= VS_LAST);
    assign w_raw[0] = (r_hcount < H_VIS) && (r_vcount < V_VIS);

    generate
        if (PIPE_DELAY == 0) begin : g_no_pipe
            assign w_delayed = w_raw;
        end else begin : g_pipe
            // Stage 0 takes the raw strobes; later stages shift one pixel per
            // pixel_en. Reset to all-zero gives inactive sync and no video.
            logic [2:0] r_pipe [PIPE_DELAY];

            always_ff @(posedge vga_clock or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < PIPE_DELAY; i++) r_pipe[i] <= '0;
                end else if (w_pixel_en) begin
                    r_pipe[0] <= w_raw;
                    for (int i = 1; i < PIPE_DELAY; i++) r_pipe[i] <= r_pipe[i-1];
                end
            end

            assign w_delayed = r_pipe[PIPE_DELAY-1];
        end
    endgenerate

    assign pixel_en    = w_pixel_en;
    assign hcount      = r_hcount;
    assign vcount      = r_vcount;
    assign xCoord      = r_hcount >> SCALE_SHIFT;
    assign yCoord      = r_vcount >> SCALE_SHIFT;
    assign VGA_HS      = w_delayed[2] ? HS_POL : ~HS_POL;
    assign VGA_VS      = w_delayed[1] ? VS_POL : ~VS_POL;
    assign visible     = w_delayed[0];
    assign VGA_SYNC_N  = 1'b1;
    assign line_start  = w_pixel_en && (r_hcount == '0);
    assign frame_start = w_pixel_en && (r_hcount == '0) && (r_vcount == '0);
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Two instances share clock, reset and enable:
//   A: H 10/2/4/3, V 5/2/2/2, CLK_DIV=3, PIPE_DELAY=2, SCALE_SHIFT=1,
//      HS_POL=0, VS_POL=1
//   B: H 8/2/3/3,  V 4/1/2/1, CLK_DIV=1, PIPE_DELAY=0, SCALE_SHIFT=2,
//      HS_POL=1, VS_POL=0
// The reference model counts enabled clock cycles since reset and derives
// every output with plain division/modulo arithmetic on that count.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  typedef struct packed {
    logic        pe;
    logic [10:0] hc;
    logic [10:0] vc;
    logic [10:0] x;
    logic [10:0] y;
    logic        hs;
    logic        vs;
    logic        vis;
    logic        ls;
    logic        fs;
    logic [15:0] fc;
  } obs_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A ----------------
  logic        a_pe, a_hs, a_vs, a_vis, a_sn, a_ls, a_fs;
  logic [10:0] a_hc, a_vc, a_x, a_y;
  logic [15:0] a_fc;
  obs_t        a_obs;

  vga_timing_gen #(
    .H_ACTIVE(10), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(5),  .V_FP(2), .V_SYNC(2), .V_BP(2),
    .CLK_DIV(3), .SCALE_SHIFT(1), .HS_POL(1'b0), .VS_POL(1'b1),
    .PIPE_DELAY(2), .CW(11)
  ) u_a (
    .vga_clock(clk), .reset(rst), .enable(en),
    .pixel_en(a_pe), .hcount(a_hc), .vcount(a_vc),
    .xCoord(a_x), .yCoord(a_y), .VGA_HS(a_hs), .VGA_VS(a_vs),
    .visible(a_vis), .VGA_SYNC_N(a_sn), .line_start(a_ls),
    .frame_start(a_fs), .frame_count(a_fc)
  );
  assign a_obs = {a_pe, a_hc, a_vc, a_x, a_y, a_hs, a_vs, a_vis, a_ls, a_fs, a_fc};

  // ---------------- DUT B ----------------
  logic        b_pe, b_hs, b_vs, b_vis, b_sn, b_ls, b_fs;
  logic [10:0] b_hc, b_vc, b_x, b_y;
  logic [15:0] b_fc;
  obs_t        b_obs;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(1), .SCALE_SHIFT(2), .HS_POL(1'b1), .VS_POL(1'b0),
    .PIPE_DELAY(0), .CW(11)
  ) u_b (
    .vga_clock(clk), .reset(rst), .enable(en),
    .pixel_en(b_pe), .hcount(b_hc), .vcount(b_vc),
    .xCoord(b_x), .yCoord(b_y), .VGA_HS(b_hs), .VGA_VS(b_vs),
    .visible(b_vis), .VGA_SYNC_N(b_sn), .line_start(b_ls),
    .frame_start(b_fs), .frame_count(b_fc)
  );
  assign b_obs = {b_pe, b_hc, b_vc, b_x, b_y, b_hs, b_vs, b_vis, b_ls, b_fs, b_fc};

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_en    = 0;      // enabled clock cycles since the last reset edge
  bit rec_fs  = 1'b0;
  int fs_a_q[$];
  int fs_b_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s @cycle %0d: got %0h, want %0h", tag, cyc, obs, exp);
    end
  endtask

  // Behavioural reference: the raster position is simply the number of
  // completed pixel periods; delayed strobes describe the pixel PIPE_DELAY
  // periods earlier (or the all-zero reset contents before that exists).
  function automatic obs_t model(input int n, input bit e, input bit r,
                                 input int ha, input int hf, input int hsw, input int hb,
                                 input int va, input int vf, input int vsw, input int vb,
                                 input int div, input int d, input int ss,
                                 input bit hp, input bit vp);
    obs_t o;
    int ht, vt, nn, p, h, v, q, hd, vd;
    bit hs_on, vs_on, vis_on;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    nn = r ? 0 : n;
    p  = nn / div;
    h  = p % ht;
    v  = (p / ht) % vt;
    hs_on = 0; vs_on = 0; vis_on = 0;
    if (p >= d) begin
      q  = p - d;
      hd = q % ht;
      vd = (q / ht) % vt;
      hs_on  = (hd >= ha + hf) && (hd < ha + hf + hsw);
      vs_on  = (vd >= va + vf) && (vd < va + vf + vsw);
      vis_on = (hd < ha) && (vd < va);
    end
    o.pe  = e && ((nn % div) == div - 1);
    o.hc  = 11'(h);
    o.vc  = 11'(v);
    o.x   = 11'(h >> ss);
    o.y   = 11'(v >> ss);
    o.hs  = hs_on ? hp : ~hp;
    o.vs  = vs_on ? vp : ~vp;
    o.vis = vis_on;
    o.ls  = o.pe && (h == 0);
    o.fs  = o.ls && (v == 0);
    o.fc  = 16'((p / (ht * vt)) % 65536);
    return o;
  endfunction

  task automatic compare_inst(input string nm, input obs_t o, input obs_t e);
    check_val({nm, ".pixel_en"},    32'(o.pe),  32'(e.pe));
    check_val({nm, ".hcount"},      32'(o.hc),  32'(e.hc));
    check_val({nm, ".vcount"},      32'(o.vc),  32'(e.vc));
    check_val({nm, ".xCoord"},      32'(o.x),   32'(e.x));
    check_val({nm, ".yCoord"},      32'(o.y),   32'(e.y));
    check_val({nm, ".VGA_HS"},      32'(o.hs),  32'(e.hs));
    check_val({nm, ".VGA_VS"},      32'(o.vs),  32'(e.vs));
    check_val({nm, ".visible"},     32'(o.vis), 32'(e.vis));
    check_val({nm, ".line_start"},  32'(o.ls),  32'(e.ls));
    check_val({nm, ".frame_start"}, 32'(o.fs),  32'(e.fs));
    check_val({nm, ".frame_count"}, 32'(o.fc),  32'(e.fc));
  endtask

  // ---------------- driver ----------------
  // One clock: advance the model on the edge using the inputs that were
  // present, drive the next inputs, then compare on the falling edge.
  task automatic drive_cycle(input bit r, input bit e);
    obs_t ea, eb;
    @(posedge clk);
    if (rst)     n_en = 0;
    else if (en) n_en++;
    #1;
    rst = r;
    en  = e;
    cyc++;
    @(negedge clk);
    ea = model(n_en, en, rst, 10, 2, 4, 3, 5, 2, 2, 2, 3, 2, 1, 1'b0, 1'b1);
    eb = model(n_en, en, rst, 8, 2, 3, 3, 4, 1, 2, 1, 1, 0, 2, 1'b1, 1'b0);
    compare_inst("A", a_obs, ea);
    compare_inst("B", b_obs, eb);
    check_val("A.VGA_SYNC_N", 32'(a_sn), 32'd1);
    check_val("B.VGA_SYNC_N", 32'(b_sn), 32'd1);
    if (rec_fs && a_fs) fs_a_q.push_back(cyc);
    if (rec_fs && b_fs) fs_b_q.push_back(cyc);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset with enable high: B's pixel_en follows enable even in reset.
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b1);

    // Free run from reset release; measure frame_start spacing.
    rec_fs = 1'b1;
    for (int i = 0; i < 1500; i++) drive_cycle(1'b0, 1'b1);
    rec_fs = 1'b0;
    check_val("A.frame_starts_seen", 32'(fs_a_q.size() >= 2), 32'd1);
    check_val("B.frame_starts_seen", 32'(fs_b_q.size() >= 2), 32'd1);
    if (fs_a_q.size() >= 2)
      check_val("A.frame_period", 32'(fs_a_q[1] - fs_a_q[0]), 32'(19 * 11 * 3));
    if (fs_b_q.size() >= 2)
      check_val("B.frame_period", 32'(fs_b_q[1] - fs_b_q[0]), 32'd128);
    // First frame_start right on the first edge after release for B,
    // CLK_DIV-th edge for A.
    if (fs_a_q.size() >= 1) check_val("A.first_frame_start", 32'(fs_a_q[0]), 32'd6);
    if (fs_b_q.size() >= 1) check_val("B.first_frame_start", 32'(fs_b_q[0]), 32'd4);

    // Pause for 50 cycles part-way through a line, then resume.
    for (int i = 0; i < 7; i++) drive_cycle(1'b0, 1'b1);
    for (int i = 0; i < 50; i++) drive_cycle(1'b0, 1'b0);
    for (int i = 0; i < 300; i++) drive_cycle(1'b0, 1'b1);

    // Mid-frame reset, then release.
    for (int i = 0; i < 2; i++) drive_cycle(1'b1, 1'b1);
    for (int i = 0; i < 800; i++) drive_cycle(1'b0, 1'b1);

    // Reset while enable is low.
    for (int i = 0; i < 2; i++) drive_cycle(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b0);

    // Randomised enable gaps with occasional resets.
    for (int i = 0; i < 3500; i++)
      drive_cycle($urandom_range(0, 399) == 0, $urandom_range(0, 4) != 0);

    for (int i = 0; i < 200; i++) drive_cycle(1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
